// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP inference back end (action selection).
// Provides the action count, Q-value format, LFSR constants and the selector FSM states.
package mlp_pkg;

    localparam int unsigned OUT_DIM = 10;
    localparam int unsigned Q_W     = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned N_W     = IDX_W + 1;
    localparam int unsigned EPS_W   = 9;
    localparam int unsigned LFSR_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [Q_W-1:0]    Q_MIN        = 16'h8000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DECIDE = 3'd2,
        PICK   = 3'd3,
        DONE   = 3'd4
    } sel_state_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with seed load.
// Ports: clk, rst (sync, active-high), load/seed (zero seed maps to LFSR_DEFAULT),
//        step (advance one position), value (current state).
module lfsr16
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    // An all-zero state would lock up, so a zero seed falls back to the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_DEFAULT;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_DEFAULT : seed;
        end else if (step) begin
            value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
        end
    end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: sequential argmax over legal Q-values, with
// optional uniform exploration among legal actions driven by a 16-bit LFSR.
// Ports: clk, rst (sync, active-high); start/q_vec/action_mask/explore_en/epsilon
//        request inputs sampled in IDLE; seed_load/seed reseed the LFSR in IDLE;
//        busy, done (1-cycle pulse), action, q_max, explored, none_valid results.
module action_selector
    import mlp_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:OUT_DIM-1][Q_W-1:0]   q_vec,
    input  logic [OUT_DIM-1:0]            action_mask,
    input  logic                          explore_en,
    input  logic [EPS_W-1:0]              epsilon,
    input  logic                          seed_load,
    input  logic [LFSR_W-1:0]             seed,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              action,
    output logic [Q_W-1:0]                q_max,
    output logic                          explored,
    output logic                          none_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_DIM - 1);

    sel_state_e state, state_nxt;

    logic [0:OUT_DIM-1][Q_W-1:0] q_r;
    logic [OUT_DIM-1:0]          mask_r;
    logic                        explore_en_r;
    logic [EPS_W-1:0]            eps_r;
    logic [IDX_W-1:0]            idx;
    logic [N_W-1:0]              cnt;
    logic signed [Q_W-1:0]       best;
    logic [IDX_W-1:0]            best_idx;
    logic [N_W-1:0]              n_valid;
    logic [N_W-1:0]              k_r;
    logic                        explore_r;
    logic [IDX_W-1:0]            sel;
    logic [LFSR_W-1:0]           lfsr_val;

    logic                        lfsr_load_c;
    logic                        lfsr_step_c;
    logic                        explore_c;
    logic [12:0]                 k_prod_c;
    logic [N_W-1:0]              k_c;
    logic                        scan_better_c;
    logic                        pick_hit_c;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load_c),
        .seed  (seed),
        .step  (lfsr_step_c),
        .value (lfsr_val)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = DECIDE;
            DECIDE:  state_nxt = explore_c ? PICK : DONE;
            PICK:    if (pick_hit_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes and per-cycle decisions
    always_comb begin
        lfsr_load_c   = (state == IDLE) && seed_load;
        lfsr_step_c   = (state == DECIDE);
        explore_c     = explore_en_r && (n_valid != '0) &&
                        ({1'b0, lfsr_val[7:0]} < eps_r);
        // Scales the upper LFSR byte onto 0..n_valid-1
        k_prod_c      = 13'(lfsr_val[15:8]) * 13'(n_valid);
        k_c           = N_W'(k_prod_c >> 8);
        // First legal element always wins so ties resolve to the lowest index
        scan_better_c = ($signed(q_r[idx]) > best) || (n_valid == '0);
        pick_hit_c    = mask_r[idx] && (cnt == k_r);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r          <= '0;
            mask_r       <= '0;
            explore_en_r <= 1'b0;
            eps_r        <= '0;
            idx          <= '0;
            cnt          <= '0;
            best         <= Q_MIN;
            best_idx     <= '0;
            n_valid      <= '0;
            k_r          <= '0;
            explore_r    <= 1'b0;
            sel          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            action       <= '0;
            q_max        <= Q_MIN;
            explored     <= 1'b0;
            none_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        q_r          <= q_vec;
                        mask_r       <= action_mask;
                        explore_en_r <= explore_en;
                        eps_r        <= epsilon;
                        idx          <= '0;
                        best         <= Q_MIN;
                        best_idx     <= '0;
                        n_valid      <= '0;
                    end
                end
                SCAN: begin
                    if (mask_r[idx]) begin
                        n_valid <= n_valid + N_W'(1);
                        if (scan_better_c) begin
                            best     <= $signed(q_r[idx]);
                            best_idx <= idx;
                        end
                    end
                    idx <= idx + IDX_W'(1);
                end
                DECIDE: begin
                    explore_r <= explore_c;
                    k_r       <= k_c;
                    idx       <= '0;
                    cnt       <= '0;
                end
                PICK: begin
                    if (pick_hit_c)       sel <= idx;
                    else if (mask_r[idx]) cnt <= cnt + N_W'(1);
                    idx <= idx + IDX_W'(1);
                end
                DONE: begin
                    done       <= 1'b1;
                    action     <= explore_r ? sel : best_idx;
                    q_max      <= best;
                    explored   <= explore_r;
                    none_valid <= (n_valid == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
